// File: rtl/rf_wr_sched.sv
// Register-file write-port scheduler: round-robin arbitration of NREQ writeback
// requesters onto a single registered write port, plus a per-register busy scoreboard.

module rf_wr_sched_busy (
  input  logic clk,
  input  logic resetn,
  input  logic i_set,
  input  logic i_clr,
  output logic o_busy
);
  // A reservation takes precedence over a same-cycle completion to the same register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)    o_busy <= 1'b0;
    else if (i_set) o_busy <= 1'b1;
    else if (i_clr) o_busy <= 1'b0;
  end
endmodule

module rf_wr_sched #(
  parameter  int NREQ = 3,
  parameter  int NREG = 16,
  localparam int AW   = $clog2(NREG),
  localparam int PW   = $clog2(NREQ)
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ-1:0][AW-1:0]   req_addr,
  input  logic [NREQ-1:0][31:0]     req_data,
  output logic [NREQ-1:0]           req_ready,
  output logic                      wr_en,
  output logic [AW-1:0]             wr_addr,
  output logic [31:0]               wr_data,
  input  logic                      rsv_valid,
  input  logic [AW-1:0]             rsv_addr,
  output logic                      rsv_stall,
  input  logic [AW-1:0]             chk_addrA,
  input  logic [AW-1:0]             chk_addrB,
  output logic                      busyA,
  output logic                      busyB
);
  logic [PW-1:0]   r_ptr;
  logic [PW-1:0]   w_gidx;
  logic            w_found;
  logic            w_xfer;
  logic [AW-1:0]   w_xaddr;
  logic [31:0]     w_xdata;
  logic [NREQ-1:0] w_gnt;
  logic [NREG-1:0] w_busy;
  logic [NREG-1:0] w_set;
  logic [NREG-1:0] w_clr;

  // Scan ptr, ptr+1, ... with wrap; first valid requester wins.
  always_comb begin
    int idx;
    w_found = 1'b0;
    w_gidx  = '0;
    w_gnt   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(r_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!w_found && req_valid[idx]) begin
        w_found = 1'b1;
        w_gidx  = PW'(idx);
      end
    end
    if (w_found && resetn) w_gnt[w_gidx] = 1'b1;
  end

  assign req_ready = w_gnt;
  assign w_xfer    = w_found & resetn;
  assign w_xaddr   = req_addr[w_gidx];
  assign w_xdata   = req_data[w_gidx];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ptr   <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= w_xfer;
      if (w_xfer) begin
        wr_addr <= w_xaddr;
        wr_data <= w_xdata;
        r_ptr   <= (w_gidx == PW'(NREQ-1)) ? '0 : w_gidx + 1'b1;
      end
    end
  end

  // A completing write to the reserved register frees it in time for the reservation.
  assign rsv_stall = rsv_valid & w_busy[rsv_addr] & ~(w_xfer && (w_xaddr == rsv_addr));

  always_comb begin
    w_set = '0;
    w_clr = '0;
    for (int r = 0; r < NREG; r++) begin
      w_set[r] = rsv_valid & ~rsv_stall & (rsv_addr == AW'(r));
      w_clr[r] = w_xfer & (w_xaddr == AW'(r));
    end
  end

  rf_wr_sched_busy u_busy [NREG-1:0] (
    .clk    (clk),
    .resetn (resetn),
    .i_set  (w_set),
    .i_clr  (w_clr),
    .o_busy (w_busy)
  );

  // Registered state only; the half-cycle RAW window is the issue stage's concern.
  assign busyA = w_busy[chk_addrA];
  assign busyB = w_busy[chk_addrB];
endmodule
